// File: rtl/fifo_pkg.sv
// Shared FIFO pointer types and Gray-code helpers for the dual-clock FIFO.
package fifo_pkg;

  localparam int ADDRSIZE = 9;
  localparam int DEPTH    = 2 ** ADDRSIZE;

  typedef logic [ADDRSIZE:0] ptr_t;

  // Helpers work on a wide word; zero-extended narrower pointers convert
  // correctly, and callers keep only the low ADDRSIZE+1 bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin = '0;
    bin[WIDTH-1] = gray[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
  end

endmodule

// File: rtl/wptr_full_level.sv
// Write-domain pointer/status controller: binary and Gray write pointers,
// registered full, fill level, programmable almost-full and sticky overflow.
module wptr_full_level
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 9
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                ovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  if (ADDRSIZE < 2) begin : g_bad_addrsize
    $error("wptr_full_level: ADDRSIZE must be >= 2");
  end

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_next;
  logic [31:0]       gray_wide;
  logic              wen;
  logic              wfull_next;
  logic              afull_next;

  // Read pointer decode; shared converter with the read-side block.
  gray2bin #(.WIDTH(ADDRSIZE + 1)) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  // Next-pointer, full, level and almost-full decode. Writes are gated by the
  // registered full flag, so a read arriving while full frees space only from
  // the following cycle.
  always_comb begin
    wen        = winc & ~wfull;
    wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wen};
    gray_wide  = bin2gray(32'(wbinnext));
    wgraynext  = gray_wide[ADDRSIZE:0];
    // Inverted MSB pair: write pointer is exactly one lap ahead of read.
    wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                wq2_rptr[ADDRSIZE-2:0]});
    level_next = wbinnext - rbin;
    afull_next = (level_next >= afull_thresh);
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  // Pointer and status registers; level and flags move on the same edge.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      walmost_full <= afull_next;
      wlevel       <= level_next;
    end
  end

  // Sticky overflow: a dropped write sets it, and beats a same-cycle clear.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wovf <= 1'b0;
    end else if (winc && wfull) begin
      wovf <= 1'b1;
    end else if (ovf_clr) begin
      wovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wptr_full_level.sv
// Directed bench for wptr_full_level with ADDRSIZE=4 (depth 16).
module tb_wptr_full_level;

  localparam int AW = 4;

  logic          wclk;
  logic          wrst_n;
  logic          winc;
  logic [AW:0]   wq2_rptr;
  logic [AW:0]   afull_thresh;
  logic          ovf_clr;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wovf;

  int n_checks = 0;
  int n_fail   = 0;

  wptr_full_level #(.ADDRSIZE(AW)) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wq2_rptr     (wq2_rptr),
    .afull_thresh (afull_thresh),
    .ovf_clr      (ovf_clr),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".waddr"}, 32'(waddr), 0);
    check({tag, ".wptr"},  32'(wptr), 0);
    check({tag, ".wfull"}, 32'(wfull), 0);
    check({tag, ".afull"}, 32'(walmost_full), 0);
    check({tag, ".wlevel"}, 32'(wlevel), 0);
    check({tag, ".wovf"},  32'(wovf), 0);
  endtask

  task automatic do_reset();
    winc = 1'b0;
    ovf_clr = 1'b0;
    wq2_rptr = '0;
    #2 wrst_n = 1'b0;
    #1 wrst_n = 1'b1;
  endtask

  function automatic logic [AW:0] gray_of(input int v);
    logic [AW:0] b;
    b = (AW + 1)'(v);
    return b ^ (b >> 1);
  endfunction

  initial begin
    wrst_n = 1'b0;
    winc = 1'b0;
    ovf_clr = 1'b0;
    wq2_rptr = '0;
    afull_thresh = 5'd12;
    #3;
    check_all_zero("reset");
    @(negedge wclk);
    wrst_n = 1'b1;

    // Reset mid-fill
    winc = 1'b1;
    repeat (5) step();
    check("midfill.waddr", 32'(waddr), 5);
    check("midfill.wlevel", 32'(wlevel), 5);
    #1 wrst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #1 wrst_n = 1'b1;
    check("post_rst.waddr", 32'(waddr), 0);
    step();
    check("post_rst.waddr1", 32'(waddr), 1);
    check("post_rst.wlevel1", 32'(wlevel), 1);
    do_reset();

    // Fill with read pointer parked at 0
    afull_thresh = 5'd12;
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 11) check("fill.afull11", 32'(walmost_full), 0);
      if (i == 12) check("fill.afull12", 32'(walmost_full), 1);
      if (i == 15) check("fill.full15", 32'(wfull), 0);
    end
    check("fill.wfull", 32'(wfull), 1);
    check("fill.wlevel", 32'(wlevel), 16);
    check("fill.wptr", 32'(wptr), 32'b11000);
    check("fill.waddr", 32'(waddr), 0);

    // Overflow
    step();
    check("ovf.wovf1", 32'(wovf), 1);
    check("ovf.wptr1", 32'(wptr), 32'b11000);
    step();
    step();
    check("ovf.wptr3", 32'(wptr), 32'b11000);
    check("ovf.wlevel3", 32'(wlevel), 16);
    winc = 1'b0;
    ovf_clr = 1'b1;
    step();
    check("ovf.clr", 32'(wovf), 0);
    winc = 1'b1;
    step();
    check("ovf.set_wins", 32'(wovf), 1);
    winc = 1'b0;
    step();
    check("ovf.clr2", 32'(wovf), 0);
    ovf_clr = 1'b0;

    // Full release: write in the release cycle is dropped
    wq2_rptr = 5'b00001;
    winc = 1'b1;
    step();
    check("rel.wfull", 32'(wfull), 0);
    check("rel.wlevel", 32'(wlevel), 15);
    check("rel.afull", 32'(walmost_full), 1);
    check("rel.wptr_hold", 32'(wptr), 32'b11000);
    step();
    check("rel.refull", 32'(wfull), 1);
    check("rel.wlevel16", 32'(wlevel), 16);
    check("rel.wptr", 32'(wptr), 32'b11001);
    winc = 1'b0;
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // Almost-full hysteresis: drain to level 12, then one more read
    for (int r = 2; r <= 5; r++) begin
      wq2_rptr = gray_of(r);
      step();
    end
    check("hyst.wlevel12", 32'(wlevel), 12);
    check("hyst.afull12", 32'(walmost_full), 1);
    wq2_rptr = gray_of(6);
    step();
    check("hyst.wlevel11", 32'(wlevel), 11);
    check("hyst.afull11", 32'(walmost_full), 0);
    afull_thresh = 5'd0;
    step();
    check("hyst.thresh0", 32'(walmost_full), 1);
    afull_thresh = 5'd12;

    // Wrap with the read pointer trailing two entries
    do_reset();
    winc = 1'b1;
    step();
    step();
    check("wrap.prime", 32'(wlevel), 2);
    for (int k = 2; k < 42; k++) begin
      wq2_rptr = gray_of((k - 1) % 32);
      step();
      check("wrap.wlevel", 32'(wlevel), 2);
      check("wrap.wfull", 32'(wfull), 0);
      check("wrap.waddr", 32'(waddr), (k + 1) % 16);
    end
    check("wrap.wptr", 32'(wptr), 32'(gray_of(42 % 32)));
    winc = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
